awgn_issue_ctrl: RTL and testbench
==================================

Name: awgn_issue_ctrl

Overview:
- Sequencer for the Box-Muller AWGN core, which is a free-running, non-stallable pipeline with fixed latency from seed inputs a/b to outputs x0/x1.
- Generates seed pairs from two internal LFSRs and issues them only when downstream buffer space is guaranteed.
- Tracks in-flight samples with a valid shift register.
- Buffers core outputs in a FIFO presented on a valid/ready stream, and runs bursts of N sample pairs or continuous operation.

Parameters:
- LATENCY, 10: cycles from a_out change to the matching core_x0/core_x1 value.
- FIFO_DEPTH, 16: output FIFO entries (power of 2, >= 4).
- SEED_A_DEF, 32'hACE1_2468: LFSR A reset / zero-replacement seed.
- SEED_B_DEF, 32'h1357_BDF9: LFSR B reset / zero-replacement seed.

Ports:
- clk  in  1  clock
- resetn  in  1  synchronous, active-low reset
- start  in  1  pulse: begin burst (ignored unless IDLE/DONE)
- stop  in  1  pulse: stop issuing, drain in-flight samples
- burst_len  in  16  pairs per burst; 0 = continuous
- seed_load  in  1  load seed_a_in/seed_b_in into LFSRs (IDLE/DONE only)
- seed_a_in  in  32  seed for LFSR A
- seed_b_in  in  32  seed for LFSR B
- a_out  out  32  seed word a to core
- b_out  out  32  seed word b to core
- core_x0  in  16  core noise output 0
- core_x1  in  16  core noise output 1
- m_valid  out  1  FIFO head valid
- m_ready  in  1  consumer accepts head
- m_x0  out  16  head sample 0
- m_x1  out  16  head sample 1
- busy  out  1  state != IDLE/DONE
- done  out  1  one-cycle pulse on entering DONE
- stat_cnt  out  32  total pairs delivered (optional feature)

Behaviour:
- Reset (resetn=0 at posedge), including mid-burst: state IDLE; LFSR A/B = SEED_A_DEF/SEED_B_DEF; a_out/b_out = 0; FIFO empty; valid pipe cleared; m_valid=0, m_x0=m_x1=0, busy=0, done=0, stat_cnt=0.
- LFSRs: 32-bit Galois, shift right; if lsb=1, XOR with 32'h8020_0003. Advance only on an issue cycle. seed_load of value 0 loads the corresponding default seed instead.
- Issue: in RUN, issue = (inflight + fifo_count < FIFO_DEPTH) && remaining != 0 (remaining unused when burst_len=0).
  - On issue: a_out/b_out <= current LFSR states; LFSRs advance; vpipe[0] <= 1; remaining decrements.
  - On a non-issue cycle, a_out/b_out hold their value and vpipe[0] <= 0.
- vpipe: LATENCY-bit shift register. When vpipe[LATENCY-1]=1, push {core_x0,core_x1} into the FIFO that cycle. inflight = popcount(vpipe), maintained as a counter. The credit check guarantees the FIFO never overflows.
- FIFO: m_valid = !empty; head is on m_x0/m_x1. Pop on m_valid && m_ready. Simultaneous push and pop is allowed, including when full or empty (count unchanged). Empty FIFO with a push lands the data next cycle (no bypass).
- States:
  - IDLE: start -> RUN; remaining <= burst_len.
  - RUN: stop, or (burst_len != 0 && remaining reaches 0 after an issue) -> DRAIN.
  - DRAIN: no issue; inflight=0 && FIFO empty -> DONE.
  - DONE: done=1 for the entry cycle only; start -> RUN; stays otherwise.
- start in RUN/DRAIN is ignored. stop in IDLE/DONE is ignored. stop in the same cycle as start from IDLE: start wins, stop ignored. seed_load outside IDLE/DONE is ignored.
- Back-to-back throughput: one pair per cycle when m_ready is held high.

Optional Feature:
- Macro AWGN_ISSUE_STATS_EN.
- Defined: stat_cnt is a 32-bit counter incremented on each FIFO pop, wrapping at 2^32; cleared only by reset.
- Undefined: stat_cnt is tied to 0 and no counter logic is present.

Test Plan:
- Reset, seed_load a=0,b=0, start with burst_len=1 -> first a_out=32'hACE1_2468, b_out=32'h1357_BDF9; m_valid rises LATENCY+1 cycles after issue; done pulses after the pop.
- burst_len=100, m_ready=1, core model = delay of LATENCY -> exactly 100 pairs, in issue order, matching the LFSR sequence; done is a single pulse; stat_cnt=100 with the macro.
- burst_len=0, m_ready=0 for 200 cycles -> issues stop at exactly FIFO_DEPTH total in flight plus buffered; no FIFO overflow. Then m_ready=1 -> issue resumes, with no loss or duplication.
- Continuous run, stop pulse -> no issue from the next cycle; all in-flight samples are drained and delivered; then DONE.
- resetn=0 mid-burst with FIFO at 7 entries -> next cycle m_valid=0, busy=0, LFSRs reloaded to defaults.
- seed_load during RUN -> ignored (LFSR sequence unchanged); start during DRAIN -> ignored.

Source files
------------

// File: rtl/awgn_issue_ctrl.sv
// awgn_issue_ctrl: sequencer for the Box-Muller AWGN core.
// It issues LFSR seed pairs to a fixed-latency core. It issues only when the
// output FIFO is sure to have room for the result. A valid shift register
// tracks samples in flight, and the core results are buffered in a FIFO that
// drives a valid/ready stream. The block runs either bursts of N pairs or
// continuous operation.
// Optional build macro: AWGN_ISSUE_STATS_EN enables the delivered-pair counter
// on stat_cnt. When the macro is undefined, stat_cnt reads as 0.
module awgn_issue_ctrl #(
  parameter int          LATENCY    = 10,
  parameter int          FIFO_DEPTH = 16,
  parameter logic [31:0] SEED_A_DEF = 32'hACE1_2468,
  parameter logic [31:0] SEED_B_DEF = 32'h1357_BDF9
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        start,
  input  logic        stop,
  input  logic [15:0] burst_len,
  input  logic        seed_load,
  input  logic [31:0] seed_a_in,
  input  logic [31:0] seed_b_in,
  output logic [31:0] a_out,
  output logic [31:0] b_out,
  input  logic [15:0] core_x0,
  input  logic [15:0] core_x1,
  output logic        m_valid,
  input  logic        m_ready,
  output logic [15:0] m_x0,
  output logic [15:0] m_x1,
  output logic        busy,
  output logic        done,
  output logic [31:0] stat_cnt
);

  localparam int          AW   = $clog2(FIFO_DEPTH);
  localparam int          CW   = $clog2(FIFO_DEPTH + 1);
  localparam int          IW   = $clog2(LATENCY + 1);
  localparam logic [31:0] POLY = 32'h8020_0003;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Galois LFSR, shifting right, with a tap XOR when the outgoing bit is 1.
  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    lfsr_step = s[0] ? ((s >> 1) ^ POLY) : (s >> 1);
  endfunction

  state_t             state;
  state_t             state_n;
  logic               done_r;
  logic [15:0]        remaining;
  logic               cont;
  logic [31:0]        lfsr_a;
  logic [31:0]        lfsr_b;
  logic [31:0]        a_q;
  logic [31:0]        b_q;
  logic [LATENCY-1:0] vpipe;
  logic [LATENCY-1:0] vpipe_n;
  logic [IW-1:0]      inflight;
  logic [15:0]        mem_x0 [FIFO_DEPTH];
  logic [15:0]        mem_x1 [FIFO_DEPTH];
  logic [AW-1:0]      wr_ptr;
  logic [AW-1:0]      rd_ptr;
  logic [CW-1:0]      count;
  logic [31:0]        occupancy;
  logic               idle_like;
  logic               issue;
  logic               push;
  logic               pop;

  // Output stream: a pair moves on each cycle where m_valid && m_ready at
  // posedge clk. m_valid stays high and m_x0/m_x1 stay stable until the pair
  // is accepted. m_valid does not depend on m_ready.

  assign idle_like = (state == ST_IDLE) || (state == ST_DONE);
  assign occupancy = 32'(inflight) + 32'(count);
  // Credit check: every sample in flight or buffered has a reserved FIFO slot.
  assign issue     = (state == ST_RUN) && (occupancy < 32'(FIFO_DEPTH)) &&
                     (cont || (remaining != 16'd0));
  assign push      = vpipe[LATENCY-1];
  assign m_valid   = (count != '0);
  assign pop       = m_valid && m_ready;
  assign m_x0      = m_valid ? mem_x0[rd_ptr] : 16'd0;
  assign m_x1      = m_valid ? mem_x1[rd_ptr] : 16'd0;
  assign a_out     = a_q;
  assign b_out     = b_q;
  assign busy      = (state == ST_RUN) || (state == ST_DRAIN);
  assign done      = done_r;

  generate
    if (LATENCY == 1) begin : g_pipe1
      assign vpipe_n = issue;
    end else begin : g_pipen
      assign vpipe_n = {vpipe[LATENCY-2:0], issue};
    end
  endgenerate

  // Next-state logic for the run sequencer.
  always_comb begin
    state_n = state;
    case (state)
      ST_IDLE:  if (start) state_n = ST_RUN;
      ST_RUN:   if (stop || (issue && !cont && (remaining == 16'd1))) state_n = ST_DRAIN;
      ST_DRAIN: if ((inflight == '0) && (count == '0)) state_n = ST_DONE;
      ST_DONE:  if (start) state_n = ST_RUN;
      default:  state_n = ST_IDLE;
    endcase
  end

  // State register, done pulse, and burst bookkeeping.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state     <= ST_IDLE;
      done_r    <= 1'b0;
      remaining <= 16'd0;
      cont      <= 1'b0;
    end else begin
      state  <= state_n;
      done_r <= (state_n == ST_DONE) && (state != ST_DONE);
      if (idle_like && start) begin
        remaining <= burst_len;
        cont      <= (burst_len == 16'd0);
      end else if (issue && !cont) begin
        remaining <= remaining - 16'd1;
      end
    end
  end

  // Seed generators and the seed words presented to the core.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      lfsr_a <= SEED_A_DEF;
      lfsr_b <= SEED_B_DEF;
      a_q    <= 32'd0;
      b_q    <= 32'd0;
    end else if (issue) begin
      a_q    <= lfsr_a;
      b_q    <= lfsr_b;
      lfsr_a <= lfsr_step(lfsr_a);
      lfsr_b <= lfsr_step(lfsr_b);
    end else if (idle_like && seed_load) begin
      // A zero seed would lock the LFSR, so the default seed is loaded instead.
      lfsr_a <= (seed_a_in == 32'd0) ? SEED_A_DEF : seed_a_in;
      lfsr_b <= (seed_b_in == 32'd0) ? SEED_B_DEF : seed_b_in;
    end
  end

  // Valid pipe mirrors the core latency, and the in-flight count tracks its popcount.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      vpipe    <= '0;
      inflight <= '0;
    end else begin
      vpipe    <= vpipe_n;
      inflight <= inflight + IW'(issue) - IW'(push);
    end
  end

  // FIFO pointers and occupancy. Push and pop may occur together at any level.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)      count <= count + CW'(1);
      else if (pop && !push) count <= count - CW'(1);
    end
  end

  // FIFO storage. It is not reset because the outputs are gated by m_valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_x0[wr_ptr] <= core_x0;
      mem_x1[wr_ptr] <= core_x1;
    end
  end

`ifdef AWGN_ISSUE_STATS_EN
  logic [31:0] stat_q;

  // Delivered-pair counter. It wraps naturally, and only reset clears it.
  always_ff @(posedge clk) begin
    if (!resetn) stat_q <= 32'd0;
    else if (pop) stat_q <= stat_q + 32'd1;
  end

  assign stat_cnt = stat_q;
`else
  assign stat_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_awgn_issue_ctrl.sv
// Testbench for awgn_issue_ctrl. The reference model works at the level of
// sequences. Each change on a_out/b_out must be the next word of the reference
// LFSR sequence. Each delivered pair must be the core result of the oldest
// seed pair not yet delivered. Samples in flight plus buffered must never
// exceed FIFO_DEPTH.
`timescale 1ns/1ps
module tb_awgn_issue_ctrl;
  localparam int          LAT   = 10;
  localparam int          DEPTH = 16;
  localparam logic [31:0] DEF_A = 32'hACE1_2468;
  localparam logic [31:0] DEF_B = 32'h1357_BDF9;

  logic        clk;
  logic        resetn;
  logic        start;
  logic        stop;
  logic [15:0] burst_len;
  logic        seed_load;
  logic [31:0] seed_a_in;
  logic [31:0] seed_b_in;
  logic [31:0] a_out;
  logic [31:0] b_out;
  logic [15:0] core_x0;
  logic [15:0] core_x1;
  logic        m_valid;
  logic        m_ready;
  logic [15:0] m_x0;
  logic [15:0] m_x1;
  logic        busy;
  logic        done;
  logic [31:0] stat_cnt;

  int checks = 0;
  int errors = 0;

  // Clock and DUT
  initial clk = 1'b0;
  always #5 clk = ~clk;

  awgn_issue_ctrl #(
    .LATENCY(LAT), .FIFO_DEPTH(DEPTH), .SEED_A_DEF(DEF_A), .SEED_B_DEF(DEF_B)
  ) dut (
    .clk(clk), .resetn(resetn), .start(start), .stop(stop), .burst_len(burst_len),
    .seed_load(seed_load), .seed_a_in(seed_a_in), .seed_b_in(seed_b_in),
    .a_out(a_out), .b_out(b_out), .core_x0(core_x0), .core_x1(core_x1),
    .m_valid(m_valid), .m_ready(m_ready), .m_x0(m_x0), .m_x1(m_x1),
    .busy(busy), .done(done), .stat_cnt(stat_cnt)
  );

  // The core result is a fixed function of the seed pair.
  function automatic logic [15:0] fold0(input logic [31:0] a);
    return a[31:16] ^ {a[7:0], a[15:8]};
  endfunction
  function automatic logic [15:0] fold1(input logic [31:0] b);
    return b[15:0] + b[31:16];
  endfunction
  function automatic logic [31:0] lfsr_next(input logic [31:0] s);
    return s[0] ? ((s >> 1) ^ 32'h8020_0003) : (s >> 1);
  endfunction

  // Core model. A pair issued in cycle t is sampled when the DUT captures it,
  // LATENCY cycles after the issue decision.
  logic [31:0] core_a [LAT-1];
  logic [31:0] core_b [LAT-1];
  always @(posedge clk) begin
    core_a[0] <= a_out;
    core_b[0] <= b_out;
    for (int i = 1; i < LAT - 1; i++) begin
      core_a[i] <= core_a[i-1];
      core_b[i] <= core_b[i-1];
    end
  end
  assign core_x0 = fold0(core_a[LAT-2]);
  assign core_x1 = fold1(core_b[LAT-2]);

  // Reference model state
  logic [31:0] mdl_a;
  logic [31:0] mdl_b;
  logic [31:0] prev_a;
  logic [31:0] prev_b;
  logic [31:0] exp_q[$];
  int          outstanding = 0;
  int          pop_total   = 0;
  int          issue_total = 0;
  bit          armed       = 1'b0;
  bit          seed_take   = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    mdl_a       = DEF_A;
    mdl_b       = DEF_B;
    prev_a      = 32'd0;
    prev_b      = 32'd0;
    exp_q.delete();
    outstanding = 0;
    pop_total   = 0;
  endtask

  // Compare process: runs every cycle on the falling edge.
  always @(negedge clk) begin
    if (armed) begin
      if (exp_q.size() == 0) chk("m_valid_nothing_owed", 32'(m_valid), 32'd0);
      chk("credit_bound", 32'(outstanding <= DEPTH), 32'd1);
`ifdef AWGN_ISSUE_STATS_EN
      chk("stat_cnt", stat_cnt, 32'(pop_total));
`else
      chk("stat_cnt_tied", stat_cnt, 32'd0);
`endif
      if (resetn) begin
        if ((a_out !== prev_a) || (b_out !== prev_b)) begin
          chk("issue_a", a_out, mdl_a);
          chk("issue_b", b_out, mdl_b);
          exp_q.push_back({fold0(mdl_a), fold1(mdl_b)});
          prev_a = a_out;
          prev_b = b_out;
          mdl_a  = lfsr_next(mdl_a);
          mdl_b  = lfsr_next(mdl_b);
          outstanding++;
          issue_total++;
        end
        if (m_valid && m_ready) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL pop_unowed actual=%h required=none", {m_x0, m_x1});
          end else begin
            chk("pop_pair", {m_x0, m_x1}, exp_q.pop_front());
          end
          outstanding--;
          pop_total++;
        end
        if (seed_load && seed_take) begin
          mdl_a = (seed_a_in == 32'd0) ? DEF_A : seed_a_in;
          mdl_b = (seed_b_in == 32'd0) ? DEF_B : seed_b_in;
        end
      end else begin
        model_reset();
      end
    end else if (resetn === 1'b0) begin
      armed = 1'b1;
      model_reset();
    end
  end

  // Driver tasks
  task automatic cyc(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic pulse_start(input logic [15:0] len, input logic with_stop);
    @(posedge clk); #1;
    burst_len = len;
    start     = 1'b1;
    stop      = with_stop;
    @(posedge clk); #1;
    start = 1'b0;
    stop  = 1'b0;
  endtask

  task automatic load_seeds(input logic [31:0] sa, input logic [31:0] sb, input bit take);
    @(posedge clk); #1;
    seed_a_in = sa;
    seed_b_in = sb;
    seed_load = 1'b1;
    seed_take = take;
    @(posedge clk); #1;
    seed_load = 1'b0;
    seed_take = 1'b0;
  endtask

  // which: 0 = m_valid, 1 = done. k counts the rising edges waited.
  task automatic wait_for(input int which, input int budget, input bit rnd, output int k);
    bit hit;
    hit = 1'b0;
    k   = 0;
    while (!hit && k < budget) begin
      @(posedge clk); #1;
      k++;
      if (rnd) m_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      hit = (which == 0) ? m_valid : done;
    end
    #1;
    checks++;
    if (!hit) begin
      errors++;
      $display("FAIL timeout_%0d actual=%0d required<%0d", which, k, budget);
    end
  endtask

  task automatic check_done_single();
    @(posedge clk); #1;
    @(negedge clk);
    chk("done_single_pulse", 32'(done), 32'd0);
    chk("busy_after_done", 32'(busy), 32'd0);
  endtask

  // Stimulus
  initial begin
    int k;
    int k2;
    int mark;
    int snap;
    int len;
    resetn    = 1'b0;
    start     = 1'b0;
    stop      = 1'b0;
    burst_len = 16'd0;
    seed_load = 1'b0;
    seed_a_in = 32'd0;
    seed_b_in = 32'd0;
    m_ready   = 1'b0;
    cyc(3);
    @(negedge clk);
    chk("rst_a_out", a_out, 32'd0);
    chk("rst_b_out", b_out, 32'd0);
    chk("rst_m_valid", 32'(m_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_m_x", {m_x0, m_x1}, 32'd0);
    @(posedge clk); #1;
    resetn = 1'b1;

    // Zero seeds select the defaults. A single-pair burst exercises latency.
    load_seeds(32'd0, 32'd0, 1'b1);
    m_ready = 1'b1;
    pulse_start(16'd1, 1'b0);
    wait_for(0, 40, 1'b0, k);
    chk("first_valid_latency", 32'(k), 32'(LAT + 1));
    chk("first_a_literal", a_out, 32'hACE1_2468);
    chk("first_b_literal", b_out, 32'h1357_BDF9);
    wait_for(1, 40, 1'b0, k2);
    chk("burst1_done_latency", 32'(k + k2), 32'(LAT + 3));
    check_done_single();

    // Back-to-back burst of 100 pairs at full throughput.
    mark = pop_total;
    pulse_start(16'd100, 1'b0);
    wait_for(1, 400, 1'b0, k);
    chk("burst100_cycles", 32'(k), 32'(100 + LAT + 2));
    chk("burst100_pairs", 32'(pop_total - mark), 32'd100);
    chk("burst100_owed", 32'(outstanding), 32'd0);
`ifdef AWGN_ISSUE_STATS_EN
    chk("stat_after_101", stat_cnt, 32'd101);
`endif
    check_done_single();

    // Continuous mode with the consumer stalled fills exactly FIFO_DEPTH credits.
    m_ready = 1'b0;
    pulse_start(16'd0, 1'b0);
    cyc(200);
    @(negedge clk); #1;
    chk("backpressure_fill", 32'(outstanding), 32'(DEPTH));
    chk("backpressure_busy", 32'(busy), 32'd1);
    @(posedge clk); #1;
    m_ready = 1'b1;
    cyc(50);
    @(negedge clk); #1;
    chk("resume_issuing", 32'(issue_total > 1 + 100 + DEPTH + 30), 32'd1);
    @(posedge clk); #1;
    stop = 1'b1;
    @(posedge clk); #1;
    stop = 1'b0;
    @(negedge clk); #1;
    snap = issue_total;
    wait_for(1, 100, 1'b0, k);
    chk("no_issue_after_stop", 32'(issue_total), 32'(snap));
    chk("stop_drained", 32'(outstanding), 32'd0);
    check_done_single();

    // When start and stop arrive together, start wins.
    mark = pop_total;
    pulse_start(16'd4, 1'b1);
    wait_for(1, 100, 1'b0, k);
    chk("start_beats_stop_pairs", 32'(pop_total - mark), 32'd4);

    // A seed_load during RUN is ignored. The model keeps its sequence.
    load_seeds($urandom, $urandom, 1'b1);
    mark = pop_total;
    pulse_start(16'd20, 1'b0);
    cyc(3);
    load_seeds(32'h1234_5678, 32'h9ABC_DEF0, 1'b0);
    wait_for(1, 500, 1'b1, k);
    chk("run_seedload_pairs", 32'(pop_total - mark), 32'd20);

    // Random bursts with random seeds and a random consumer.
    for (int r = 0; r < 4; r++) begin
      len = $urandom_range(1, 40);
      load_seeds(($urandom_range(0, 3) == 0) ? 32'd0 : $urandom, $urandom, 1'b1);
      mark = pop_total;
      pulse_start(16'(len), 1'b0);
      wait_for(1, 2000, 1'b1, k);
      chk("rand_burst_pairs", 32'(pop_total - mark), 32'(len));
      chk("rand_burst_owed", 32'(outstanding), 32'd0);
    end

    // A start during DRAIN is ignored.
    m_ready = 1'b0;
    mark = pop_total;
    pulse_start(16'd5, 1'b0);
    cyc(8);
    pulse_start(16'd50, 1'b0);
    m_ready = 1'b1;
    wait_for(1, 200, 1'b0, k);
    chk("drain_start_ignored", 32'(pop_total - mark), 32'd5);

    // Reset in mid-burst while the FIFO holds 7 entries.
    m_ready = 1'b0;
    pulse_start(16'd7, 1'b0);
    cyc(25);
    @(negedge clk); #1;
    chk("pre_reset_owed", 32'(outstanding), 32'd7);
    chk("pre_reset_busy", 32'(busy), 32'd1);
    @(posedge clk); #1;
    resetn = 1'b0;
    @(posedge clk); #1;
    resetn = 1'b1;
    @(negedge clk);
    chk("mid_reset_m_valid", 32'(m_valid), 32'd0);
    chk("mid_reset_busy", 32'(busy), 32'd0);
    chk("mid_reset_done", 32'(done), 32'd0);
    m_ready = 1'b1;
    pulse_start(16'd3, 1'b0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("reload_a_literal", a_out, 32'hACE1_2468);
    chk("reload_b_literal", b_out, 32'h1357_BDF9);
    @(posedge clk); #1;
    @(negedge clk);
    chk("second_a_literal", a_out, 32'h5670_9234);
    chk("second_b_literal", b_out, 32'h898B_DEFF);
    wait_for(1, 100, 1'b0, k);
    chk("post_reset_owed", 32'(outstanding), 32'd0);

    cyc(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
